// File: rtl/timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// timer_run_ctrl
// Run/pause/expire controller for a 00.00..99.99 stopwatch / countdown timer.
// Synchronizes the Start/Stop button and mode switch, filters the button,
// derives a 100 Hz tick while running, and drives the counter strobes and the
// blinking decimal point.
//
// Optional feature: define TIMER_DEBOUNCE_EN to build the StartStop debounce
// filter (DEB_CYCLES stable cycles). Without it the filtered level is the
// synchronized input and no debounce counter exists.
//
// Ports
//   CLK_50MHz  in   system clock, all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   StartStop  in   raw push-button, active-low, asynchronous
//   ModeSel    in   asynchronous mode select (0 stopwatch, 1 countdown)
//   cnt_zero   in   counter reads 00.00
//   cnt_max    in   counter reads 99.99
//   cnt_en     out  one-cycle count-step strobe
//   cnt_dir    out  count direction (0 up, 1 down) = synchronized mode
//   cnt_clr    out  one-cycle clear-to-00.00 strobe
//   cnt_load   out  one-cycle countdown-preset load strobe
//   running    out  state is RUN
//   expired    out  state is EXPIRED
//   DOT        out  decimal-point drive
// -----------------------------------------------------------------------------
module timer_run_ctrl #(
  parameter int TICK_DIV    = 500000,
  parameter int DEB_CYCLES  = 1000000,
  parameter int BLINK_TICKS = 50
) (
  input  logic CLK_50MHz,
  input  logic rst,
  input  logic StartStop,
  input  logic ModeSel,
  input  logic cnt_zero,
  input  logic cnt_max,
  output logic cnt_en,
  output logic cnt_dir,
  output logic cnt_clr,
  output logic cnt_load,
  output logic running,
  output logic expired,
  output logic DOT
);

  // The blink counter counts ticks in RUN and raw cycles in EXPIRED, so it is
  // sized for the longer of the two periods.
  localparam int BLINK_CYC = BLINK_TICKS * TICK_DIV;
  localparam int DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLK_W     = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0] TICK_LAST = BLK_W'(BLINK_TICKS - 1);
  localparam logic [BLK_W-1:0] CYC_LAST  = BLK_W'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  logic             r_mode_s1, r_mode_s2, r_mode_prev;
  logic             r_ss_s1, r_ss_s2, r_ss_prev;
  logic             r_init;
  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [BLK_W-1:0] r_blink;

  logic             w_ss_filt;
  logic             w_mode_chg;
  logic             w_press;
  logic             w_tick;
  logic             w_limit;
  logic             w_en;
  logic             w_clr;
  logic             w_load;
  state_t           w_state_nxt;

  // Two-flop synchronizers for both asynchronous inputs.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
      r_ss_s1   <= 1'b0;
      r_ss_s2   <= 1'b0;
    end else begin
      r_mode_s1 <= ModeSel;
      r_mode_s2 <= r_mode_s1;
      r_ss_s1   <= StartStop;
      r_ss_s2   <= r_ss_s1;
    end
  end

`ifdef TIMER_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  // The released button reads high, so the filtered level and its edge
  // detector both start high and no press is seen out of reset.
  localparam logic SS_PREV_RST = 1'b1;

  logic             r_ss_filt;
  logic [DEB_W-1:0] r_deb_cnt;

  // Debounce: adopt the synchronized level only after it has differed from
  // the filtered level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_ss_filt <= 1'b1;
      r_deb_cnt <= {DEB_W{1'b0}};
    end else if (r_ss_s2 == r_ss_filt) begin
      r_ss_filt <= r_ss_filt;
      r_deb_cnt <= {DEB_W{1'b0}};
    end else if (r_deb_cnt == DEB_LAST) begin
      r_ss_filt <= r_ss_s2;
      r_deb_cnt <= {DEB_W{1'b0}};
    end else begin
      r_ss_filt <= r_ss_filt;
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_ss_filt = r_ss_filt;
`else
  // The synchronizer leaves reset low; starting the edge detector low as well
  // keeps the rising settle after reset from looking like a press.
  localparam logic SS_PREV_RST = 1'b0;

  assign w_ss_filt = r_ss_s2;
`endif

  // Previous-cycle copies for edge detection, plus the post-reset init flag.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_ss_prev   <= SS_PREV_RST;
      r_mode_prev <= 1'b0;
      r_init      <= 1'b1;
    end else begin
      r_ss_prev   <= w_ss_filt;
      r_mode_prev <= r_mode_s2;
      r_init      <= 1'b0;
    end
  end

  assign w_mode_chg = r_mode_s2 ^ r_mode_prev;
  assign w_press    = r_ss_prev & ~w_ss_filt;
  assign w_tick     = (r_state == S_RUN) && (r_div == DIV_LAST);
  assign w_limit    = r_mode_s2 ? cnt_zero : cnt_max;
  assign w_en       = w_tick & ~w_limit;
  assign cnt_dir    = r_mode_s2;

  // Next-state and strobe decode; mode change outranks press, press outranks
  // the limit check on a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    if (r_init) begin
      w_clr  = ~r_mode_s2;
      w_load = r_mode_s2;
    end else if (w_mode_chg) begin
      w_state_nxt = S_IDLE;
      w_clr       = ~r_mode_s2;
      w_load      = r_mode_s2;
    end else if (w_press) begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_RUN;
        S_RUN:     w_state_nxt = S_PAUSE;
        S_PAUSE:   w_state_nxt = S_RUN;
        S_EXPIRED: begin
          w_state_nxt = S_IDLE;
          w_load      = 1'b1;
        end
        default:   w_state_nxt = S_IDLE;
      endcase
    end else if (w_tick && w_limit) begin
      // Countdown hits 00.00 -> expire; stopwatch hits 99.99 -> saturate.
      w_state_nxt = r_mode_s2 ? S_EXPIRED : S_PAUSE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and registered counter strobes / status outputs.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_state  <= S_IDLE;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      cnt_load <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      cnt_en   <= w_en;
      cnt_clr  <= w_clr;
      cnt_load <= w_load;
      running  <= (w_state_nxt == S_RUN);
      expired  <= (w_state_nxt == S_EXPIRED);
    end
  end

  // Tick divider: counts only while staying in RUN, so a partial period is
  // dropped whenever RUN is left or re-entered.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_div <= {DIV_W{1'b0}};
    end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
      r_div <= w_tick ? {DIV_W{1'b0}} : (r_div + 1'b1);
    end else begin
      r_div <= {DIV_W{1'b0}};
    end
  end

  // Decimal point: steady in IDLE/PAUSE, tick-paced blink in RUN, free-running
  // cycle-paced blink in EXPIRED; each blinking state restarts lit.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      r_blink <= {BLK_W{1'b0}};
      DOT     <= 1'b1;
    end else begin
      case (w_state_nxt)
        S_RUN: begin
          if (r_state != S_RUN) begin
            r_blink <= {BLK_W{1'b0}};
            DOT     <= 1'b1;
          end else if (w_tick && (r_blink == TICK_LAST)) begin
            r_blink <= {BLK_W{1'b0}};
            DOT     <= ~DOT;
          end else if (w_tick) begin
            r_blink <= r_blink + 1'b1;
            DOT     <= DOT;
          end else begin
            r_blink <= r_blink;
            DOT     <= DOT;
          end
        end
        S_EXPIRED: begin
          if (r_state != S_EXPIRED) begin
            r_blink <= {BLK_W{1'b0}};
            DOT     <= 1'b1;
          end else if (r_blink == CYC_LAST) begin
            r_blink <= {BLK_W{1'b0}};
            DOT     <= ~DOT;
          end else begin
            r_blink <= r_blink + 1'b1;
            DOT     <= DOT;
          end
        end
        default: begin
          r_blink <= {BLK_W{1'b0}};
          DOT     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_run_ctrl
// Self-checking bench for timer_run_ctrl (TICK_DIV=10, DEB_CYCLES=4,
// BLINK_TICKS=2). A behavioural model tracks time spent in each state and
// derives ticks and the DOT phase arithmetically; it is compared with every
// output after every clock edge. A table of directed windows adds hand-derived
// end-of-window checks, followed by a few timed corner sequences and a
// randomized run.
// -----------------------------------------------------------------------------
module tb_timer_run_ctrl;

  localparam int T = 10;
  localparam int D = 4;
  localparam int B = 2;
`ifdef TIMER_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, ss, mode, zero, maxv;
  logic cnt_en, cnt_dir, cnt_clr, cnt_load, running, expired, dot;

  always #5 clk = ~clk;

  timer_run_ctrl #(.TICK_DIV(T), .DEB_CYCLES(D), .BLINK_TICKS(B)) dut (
    .CLK_50MHz(clk), .rst(rst), .StartStop(ss), .ModeSel(mode),
    .cnt_zero(zero), .cnt_max(maxv), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .running(running),
    .expired(expired), .DOT(dot)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mst_t;
  mst_t m_st;
  bit   m_ms1, m_ms2, m_mprev, m_ss1, m_ss2, m_filt, m_fprev, m_init;
  bit   m_en, m_clr, m_load;
  bit   hist[$];
  int   m_run_cyc, m_run_ticks, m_exp_cyc;

  function automatic void model_reset();
    m_st = M_IDLE;
    m_ms1 = 0; m_ms2 = 0; m_mprev = 0; m_ss1 = 0; m_ss2 = 0;
    m_filt = 1; m_fprev = DEB_ON; m_init = 1;
    m_en = 0; m_clr = 0; m_load = 0;
    hist.delete();
    m_run_cyc = 0; m_run_ticks = 0; m_exp_cyc = 0;
  endfunction

  function automatic void model_edge(input bit r, input bit s, input bit md,
                                     input bit z, input bit mx);
    bit filt_now, press, chg, tick, lim, all_diff;
    mst_t nst;
    if (r) begin
      model_reset();
      return;
    end
    filt_now = DEB_ON ? m_filt : m_ss2;
    press    = m_fprev && !filt_now;
    chg      = (m_ms2 != m_mprev);
    tick     = (m_st == M_RUN) && ((m_run_cyc % T) == T - 1);
    lim      = m_ms2 ? z : mx;
    nst = m_st; m_clr = 0; m_load = 0;
    if (m_init) begin
      m_clr = !m_ms2; m_load = m_ms2;
    end else if (chg) begin
      nst = M_IDLE; m_clr = !m_ms2; m_load = m_ms2;
    end else if (press) begin
      if (m_st == M_IDLE || m_st == M_PAUSE) nst = M_RUN;
      else if (m_st == M_RUN) nst = M_PAUSE;
      else begin nst = M_IDLE; m_load = 1; end
    end else if (tick && lim) begin
      nst = m_ms2 ? M_EXPIRED : M_PAUSE;
    end
    m_en = tick && !lim;
    if (nst == M_RUN) begin
      if (m_st == M_RUN) begin
        m_run_cyc++;
        if (tick) m_run_ticks++;
      end else begin
        m_run_cyc = 0; m_run_ticks = 0;
      end
    end
    if (nst == M_EXPIRED) m_exp_cyc = (m_st == M_EXPIRED) ? m_exp_cyc + 1 : 0;
    // Filter: flip once the last D synchronized samples all disagree.
    if (DEB_ON) begin
      hist.push_back(m_ss2);
      if (hist.size() > D) void'(hist.pop_front());
      all_diff = (hist.size() == D);
      foreach (hist[k]) if (hist[k] == m_filt) all_diff = 0;
      if (all_diff) m_filt = m_ss2;
    end
    m_fprev = filt_now;
    m_mprev = m_ms2; m_ms2 = m_ms1; m_ms1 = md;
    m_ss2 = m_ss1;   m_ss1 = s;
    m_init = 0;
    m_st = nst;
  endfunction

  function automatic bit model_dot();
    if (m_st == M_RUN)     return ((m_run_ticks / B) % 2) == 0;
    if (m_st == M_EXPIRED) return ((m_exp_cyc / (B * T)) % 2) == 0;
    return 1'b1;
  endfunction

  // ---------------- stepping and window statistics ----------------
  int w_en, w_clr, w_load, w_run;

  task automatic step();
    logic [6:0] act, expv;
    @(posedge clk);
    model_edge(rst, ss, mode, zero, maxv);
    @(negedge clk);
    cyc++;
    act  = {cnt_en, cnt_clr, cnt_load, running, expired, dot, cnt_dir};
    expv = {m_en, m_clr, m_load, m_st == M_RUN, m_st == M_EXPIRED,
            model_dot(), m_ms2};
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL model cyc %0d {en,clr,load,run,exp,dot,dir}: got %b want %b",
               cyc, act, expv);
    end
    w_en   += int'(cnt_en === 1'b1);
    w_clr  += int'(cnt_clr === 1'b1);
    w_load += int'(cnt_load === 1'b1);
    w_run  += int'(running === 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_win();
    w_en = 0; w_clr = 0; w_load = 0; w_run = 0;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    if (expv >= 0) begin
      n_tests++;
      if (act != expv) begin
        n_fail++;
        $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
    end
  endtask

  // ---------------- directed window table ----------------
  typedef struct {
    bit r; bit s; bit md; bit z; bit mx; int n;
    int e_run; int e_exp; int e_dot; int e_dir; int e_en; int e_clr; int e_load;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(bit r, bit s, bit md, bit z, bit mx, int n,
                              int er, int ee, int ed, int edir,
                              int een, int ec, int el);
    vec_t v;
    v.r = r; v.s = s; v.md = md; v.z = z; v.mx = mx; v.n = n;
    v.e_run = er; v.e_exp = ee; v.e_dot = ed; v.e_dir = edir;
    v.e_en = een; v.e_clr = ec; v.e_load = el;
    return v;
  endfunction

  initial begin
    bit bs;
    int pe, hold;
    bs = DEB_ON ? 1'b0 : 1'b1;   // a 1-cycle glitch is a real press without the filter
    //               r  s  md z  mx  n  run exp dot dir en clr load
    vecs[0]  = mk(1, 1, 0, 0, 0,  3,  0,  0,  1,  0,  0,  0,  0);
    vecs[1]  = mk(0, 1, 0, 0, 0,  5,  0,  0,  1,  0,  0,  1,  0);
    vecs[2]  = mk(0, bs,0, 0, 0,  1,  0,  0,  1,  0,  0,  0,  0);
    vecs[3]  = mk(0, 1, 0, 0, 0,  1,  0,  0,  1,  0,  0,  0,  0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  8,  1,  0,  1,  0,  0,  0,  0);
    vecs[5]  = mk(0, 1, 0, 0, 0, 30,  1,  0,  0,  0,  3,  0,  0);
    vecs[6]  = mk(0, 1, 0, 0, 1, 10,  0,  0,  1,  0,  0,  0,  0);
    vecs[7]  = mk(0, 0, 0, 0, 0,  8,  1,  0,  1,  0,  0,  0,  0);
    vecs[8]  = mk(0, 1, 0, 0, 0,  5,  1,  0, -1,  0, -1,  0,  0);
    vecs[9]  = mk(0, 1, 1, 0, 0,  6,  0,  0,  1,  1,  0,  0,  1);
    vecs[10] = mk(0, 0, 1, 0, 0,  8,  1,  0,  1,  1,  0,  0,  0);
    vecs[11] = mk(0, 1, 1, 1, 0, 20,  0,  1,  1,  1,  0,  0,  0);
    vecs[12] = mk(0, 1, 1, 1, 0, 10,  0,  1,  0,  1,  0,  0,  0);
    vecs[13] = mk(0, 0, 1, 1, 0,  8,  0,  0,  1,  1,  0,  0,  1);
    vecs[14] = mk(0, 1, 1, 0, 0,  6,  0,  0,  1,  1,  0,  0,  0);

    model_reset();
    rst = 1'b1; ss = 1'b1; mode = 1'b0; zero = 1'b0; maxv = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      rst = vecs[v].r; ss = vecs[v].s; mode = vecs[v].md;
      zero = vecs[v].z; maxv = vecs[v].mx;
      clr_win();
      steps(vecs[v].n);
      chk($sformatf("vec%0d running", v), int'(running), vecs[v].e_run);
      chk($sformatf("vec%0d expired", v), int'(expired), vecs[v].e_exp);
      chk($sformatf("vec%0d dot", v),     int'(dot),     vecs[v].e_dot);
      chk($sformatf("vec%0d dir", v),     int'(cnt_dir), vecs[v].e_dir);
      chk($sformatf("vec%0d en_count", v),   w_en,   vecs[v].e_en);
      chk($sformatf("vec%0d clr_count", v),  w_clr,  vecs[v].e_clr);
      chk($sformatf("vec%0d load_count", v), w_load, vecs[v].e_load);
    end

    // Press and mode change landing on the same FSM edge from PAUSE.
    // Mode is countdown here; reach PAUSE with cnt_zero low.
    ss = 1'b0; steps(8);
    ss = 1'b1; steps(8);
    ss = 1'b0; steps(8);
    chk("pause running", int'(running), 0);
    ss = 1'b1; steps(8);
    clr_win();
    ss = 1'b0;
    steps(DEB_ON ? D : 0);       // align the filtered press with the mode edge
    mode = 1'b0;
    steps(10);
    chk("same-cycle run_seen", w_run, 0);
    chk("same-cycle clr_count", w_clr, 1);
    chk("same-cycle running", int'(running), 0);
    ss = 1'b1; steps(8);

    // Reset asserted on the edge that would register a count strobe.
    pe   = 2 + (DEB_ON ? D : 0);
    hold = T - 1 - (8 - 1 - pe);
    ss = 1'b0; steps(8);
    ss = 1'b1; steps(hold);
    clr_win();
    rst = 1'b1; steps(3);
    chk("mid-run reset en_count", w_en, 0);
    chk("mid-run reset running", int'(running), 0);
    chk("mid-run reset dot", int'(dot), 1);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11, 0) == 0)  ss   = ~ss;
      if ($urandom_range(149, 0) == 0) mode = ~mode;
      zero = ($urandom_range(7, 0) == 0);
      maxv = ($urandom_range(7, 0) == 0);
      rst  = ($urandom_range(699, 0) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
